// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared state encodings and datapath widths for the memory stage
package mem_stage_lsu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - EX, data-memory and write-back signal bundle for the memory stage
interface mem_stage_lsu_if
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic              ex_valid;
  logic              ex_ready;
  logic              ex_is_load;
  logic              ex_is_store;
  logic              ex_reg_write;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  logic              wb_valid;
  logic              wb_we;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  // slave: the memory stage itself; master: EX, data memory and write-back around it
  modport slave (
    input  ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_result, ex_store_data, ex_rd,
    input  dmem_req_ready, dmem_rvalid, dmem_rdata,
    output ex_ready, dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, err
  );

  modport master (
    output ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_result, ex_store_data, ex_rd,
    output dmem_req_ready, dmem_rvalid, dmem_rdata,
    input  ex_ready, dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, err
  );

endinterface

// File: rtl/lsu_timeout_ctr.sv
// rtl/lsu_timeout_ctr.sv - load-response watchdog; expired flags the last permitted WAIT cycle
module lsu_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT_CYC))) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of WAIT cycles already spent, so TIMEOUT_CYC-1 marks the final one
  assign expired = enable && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory stage: LW/SW handshake to data memory, pass-through for ALU ops
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_WORDS = 1024,
  parameter int TIMEOUT_CYC = 255
) (
  input logic            clk,
  input logic            rst_n,
  mem_stage_lsu_if.slave bus
);

  lsu_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_W-1:0]  rd_q;
  logic              we_q;

  logic              wb_valid_q, wb_we_q, err_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  logic              capture;
  logic              beat, beat_we, beat_err, beat_upd;
  logic [REG_W-1:0]  beat_rd;
  logic [DATA_W-1:0] beat_data;
  logic              ctr_clear, ctr_en, expired;
  logic              addr_ok, is_mem, bad_op;

  // full-width unsigned compare so high garbage bits can never alias a legal word
  assign addr_ok = (bus.ex_result < 32'(DEPTH_WORDS));
  assign is_mem  = bus.ex_is_load | bus.ex_is_store;
  assign bad_op  = (bus.ex_is_load & bus.ex_is_store) | !addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    beat      = 1'b0;
    beat_we   = 1'b0;
    beat_err  = 1'b0;
    beat_upd  = 1'b0;
    beat_rd   = rd_q;
    beat_data = bus.ex_result;
    ctr_clear = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (bus.ex_valid) begin
          if (!is_mem) begin
            beat      = 1'b1;
            beat_we   = bus.ex_reg_write;
            beat_upd  = 1'b1;
            beat_rd   = bus.ex_rd;
            beat_data = bus.ex_result;
          end else if (bad_op) begin
            beat     = 1'b1;
            beat_err = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (bus.dmem_req_ready) begin
          if (we_q) begin
            beat    = 1'b1;
            state_d = LSU_IDLE;
          end else begin
            ctr_clear = 1'b1;
            state_d   = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        // a response on the expiring cycle still counts as a successful load
        if (bus.dmem_rvalid) begin
          beat      = 1'b1;
          beat_we   = 1'b1;
          beat_upd  = 1'b1;
          beat_data = bus.dmem_rdata;
          state_d   = LSU_IDLE;
        end else if (expired) begin
          beat     = 1'b1;
          beat_err = 1'b1;
          state_d  = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  assign ctr_en = (state_q == LSU_WAIT);

  lsu_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else if (capture) begin
      addr_q  <= bus.ex_result[ADDR_W-1:0];
      wdata_q <= bus.ex_store_data;
      rd_q    <= bus.ex_rd;
      we_q    <= bus.ex_is_store;
    end
  end

  // wb_rd/wb_data only move on beats that carry a result; store and error beats leave them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      err_q      <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= beat;
      wb_we_q    <= beat & beat_we;
      err_q      <= beat & beat_err;
      if (beat_upd) begin
        wb_rd_q   <= beat_rd;
        wb_data_q <= beat_data;
      end
    end
  end

  assign bus.ex_ready       = (state_q == LSU_IDLE);
  assign bus.dmem_req_valid = (state_q == LSU_REQ);
  assign bus.dmem_we        = we_q;
  assign bus.dmem_addr      = addr_q;
  assign bus.dmem_wdata     = wdata_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_we          = wb_we_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed scoreboard bench for the memory stage
module tb_mem_stage_lsu;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int T      = 255;

  typedef struct {
    logic        we;
    logic        err;
    logic        chk;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];

  mem_stage_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stage_lsu #(
    .ADDR_W     (ADDR_W),
    .DEPTH_WORDS(DEPTH),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic err, input logic chk,
                              input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.we = we; e.err = err; e.chk = chk; e.rd = rd; e.data = data;
    return e;
  endfunction

  // Monitor: every write-back beat must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (bus.wb_valid || bus.err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {30'd0, bus.err, bus.wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("beat_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("beat_err", {31'd0, bus.err}, {31'd0, e.err});
        check("beat_we", {31'd0, bus.wb_we}, {31'd0, e.we});
        if (e.chk) begin
          check("beat_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
          check("beat_data", bus.wb_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ld, input logic st, input logic rw,
                      input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd);
    int n;
    bus.ex_is_load    = ld;
    bus.ex_is_store   = st;
    bus.ex_reg_write  = rw;
    bus.ex_result     = res;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    bus.ex_valid      = 1'b1;
    n = 0;
    while (!bus.ex_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("ex_ready_timeout", 32'd0, 32'd1);
    tick();
    bus.ex_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0; bus.ex_is_store = 1'b0;
    bus.ex_reg_write = 1'b0; bus.ex_result = '0; bus.ex_store_data = '0; bus.ex_rd = '0;
    bus.dmem_req_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    tick();
    tick();
    check("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    check("rst_req_valid", {31'd0, bus.dmem_req_valid}, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_addr", {22'd0, bus.dmem_addr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU pass-through, with and without register write
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0042));
    send(1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 5'd8);
    check("add_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0077));
    send(1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd12);
    tick();

    // SW with three cycles of back-pressure
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
    send(1'b0, 1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF, 5'd0);
    for (int i = 0; i < 4; i++) begin
      check("sw_req_valid", {31'd0, bus.dmem_req_valid}, 32'd1);
      check("sw_addr", {22'd0, bus.dmem_addr}, 32'd5);
      check("sw_we", {31'd0, bus.dmem_we}, 32'd1);
      check("sw_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
      check("sw_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
      bus.dmem_req_ready = (i == 3);
      tick();
    end
    bus.dmem_req_ready = 1'b0;
    check("sw_req_drop", {31'd0, bus.dmem_req_valid}, 32'd0);
    tick();

    // LW, response two cycles after the handshake
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 5'd3, 32'h1234_5678));
    send(1'b1, 1'b0, 1'b0, 32'd7, 32'h0, 5'd3);
    check("lw_addr", {22'd0, bus.dmem_addr}, 32'd7);
    check("lw_we", {31'd0, bus.dmem_we}, 32'd0);
    check("lw_ex_ready_req", {31'd0, bus.ex_ready}, 32'd0);
    bus.dmem_req_ready = 1'b1;
    tick();
    bus.dmem_req_ready = 1'b0;
    check("lw_ex_ready_w1", {31'd0, bus.ex_ready}, 32'd0);
    tick();
    check("lw_ex_ready_w2", {31'd0, bus.ex_ready}, 32'd0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1234_5678;
    tick();
    bus.dmem_rvalid = 1'b0;
    check("lw_back_idle", {31'd0, bus.ex_ready}, 32'd1);
    tick();

    // Illegal requests: first out-of-range word, high-bit alias, both flags
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
    send(1'b1, 1'b0, 1'b0, 32'd1024, 32'h0, 5'd4);
    check("oob_no_req", {31'd0, bus.dmem_req_valid}, 32'd0);
    check("oob_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
    send(1'b0, 1'b1, 1'b0, 32'h0001_0005, 32'h5555_5555, 5'd0);
    check("alias_no_req", {31'd0, bus.dmem_req_valid}, 32'd0);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
    send(1'b1, 1'b1, 1'b0, 32'd2, 32'h0, 5'd6);
    check("both_no_req", {31'd0, bus.dmem_req_valid}, 32'd0);
    tick();
    // Highest legal word still goes to memory
    send(1'b1, 1'b0, 1'b0, 32'd1023, 32'h0, 5'd9);
    check("max_req_valid", {31'd0, bus.dmem_req_valid}, 32'd1);
    check("max_addr", {22'd0, bus.dmem_addr}, 32'd1023);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h0BAD_F00D));
    bus.dmem_req_ready = 1'b1;
    tick();
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h0BAD_F00D;
    tick();
    bus.dmem_rvalid = 1'b0;
    tick();

    // LW that never gets a response: abort after T WAIT cycles
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
    send(1'b1, 1'b0, 1'b0, 32'd9, 32'h0, 5'd10);
    bus.dmem_req_ready = 1'b1;
    tick();
    bus.dmem_req_ready = 1'b0;
    for (int i = 0; i < T - 1; i++) tick();
    check("to_not_yet", {31'd0, bus.err}, 32'd0);
    check("to_still_wait", {31'd0, bus.ex_ready}, 32'd0);
    tick();
    check("to_err", {31'd0, bus.err}, 32'd1);
    check("to_idle", {31'd0, bus.ex_ready}, 32'd1);
    tick();

    // Response arriving on the final WAIT cycle wins over the abort
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 5'd11, 32'hCAFE_F00D));
    send(1'b1, 1'b0, 1'b0, 32'd11, 32'h0, 5'd11);
    bus.dmem_req_ready = 1'b1;
    tick();
    bus.dmem_req_ready = 1'b0;
    for (int i = 0; i < T - 1; i++) tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hCAFE_F00D;
    tick();
    bus.dmem_rvalid = 1'b0;
    check("race_no_err", {31'd0, bus.err}, 32'd0);
    tick();

    // Reset in WAIT, then a stale response after release
    send(1'b1, 1'b0, 1'b0, 32'd4, 32'h0, 5'd13);
    bus.dmem_req_ready = 1'b1;
    tick();
    bus.dmem_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    check("mid_rst_req", {31'd0, bus.dmem_req_valid}, 32'd0);
    check("mid_rst_wb", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h9999_9999;
    tick();
    bus.dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_wb", {31'd0, bus.wb_valid}, 32'd0);
      check("stale_err", {31'd0, bus.err}, 32'd0);
      check("stale_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
      tick();
    end

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    check("beats_outstanding", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
